fetch_sequencer: RTL and testbench

- Top-level instruction sequencer for the simple CPU.
- Fetches each instruction from synchronous memory into the instruction register (IR) and advances the PC.
- Hands execution to the existing datapath controller through its start/waiting handshake, then waits for it to return to its wait state.
- Adds HALT decode, run/pause control, instruction counting and an execution timeout fault.

---
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches into the IR, advances the PC,
// hands each instruction to the datapath controller and supervises its return.
module fetch_sequencer #(
    parameter int           CNT_W   = 16,
    parameter int           TIMEOUT = 32,
    parameter logic [2:0]   HALT_OP = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             waiting,
    input  logic [2:0]       ir_opcode,
    output logic             mem_rd,
    output logic             load_ir,
    output logic             load_pc,
    output logic             reset_pc,
    output logic             start,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_IF1       = 4'd1,
        S_IF2       = 4'd2,
        S_UPD_PC    = 4'd3,
        S_DECODE    = 4'd4,
        S_EXEC_ACK  = 4'd5,
        S_EXEC_WAIT = 4'd6,
        S_PAUSE     = 4'd7,
        S_HALT      = 4'd8,
        S_FAULT     = 4'd9
    } state_t;

    localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_r;
    state_t           nxt_state_s;
    logic [7:0]       tmo_r;
    logic [CNT_W-1:0] instr_count_r;
    logic             mem_rd_r;
    logic             load_ir_r;
    logic             load_pc_r;
    logic             reset_pc_r;
    logic             halted_r;
    logic             fault_r;
    logic             start_s;

    // Output vector {mem_rd, load_ir, load_pc, reset_pc, halted, fault} for a state
    function automatic logic [5:0] out_decode(input state_t s);
        case (s)
            S_RST:    out_decode = 6'b001100;
            S_IF1:    out_decode = 6'b100000;
            S_IF2:    out_decode = 6'b110000;
            S_UPD_PC: out_decode = 6'b001000;
            S_HALT:   out_decode = 6'b000010;
            S_FAULT:  out_decode = 6'b000001;
            default:  out_decode = 6'b000000;
        endcase
    endfunction

    // start depends on the opcode held in the IR, which is only valid once DECODE is reached
    assign start_s = (state_r == S_DECODE) && (ir_opcode != HALT_OP);

    // Next-state selection
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            S_RST:       nxt_state_s = run ? S_IF1 : S_RST;
            S_IF1:       nxt_state_s = S_IF2;
            S_IF2:       nxt_state_s = S_UPD_PC;
            S_UPD_PC:    nxt_state_s = S_DECODE;
            S_DECODE:    nxt_state_s = (ir_opcode == HALT_OP) ? S_HALT : S_EXEC_ACK;
            S_EXEC_ACK:  nxt_state_s = S_EXEC_WAIT;
            S_EXEC_WAIT: begin
                // a returning controller wins over an expiring timeout
                if (waiting) begin
                    nxt_state_s = run ? S_IF1 : S_PAUSE;
                end else if (tmo_r == TMO_LAST) begin
                    nxt_state_s = S_FAULT;
                end else begin
                    nxt_state_s = S_EXEC_WAIT;
                end
            end
            S_PAUSE:     nxt_state_s = run ? S_IF1 : S_PAUSE;
            S_HALT:      nxt_state_s = S_HALT;
            S_FAULT:     nxt_state_s = S_FAULT;
            default:     nxt_state_s = S_RST;
        endcase
    end

    // State, registered outputs, retired-instruction and timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_RST;
            {mem_rd_r, load_ir_r, load_pc_r, reset_pc_r, halted_r, fault_r} <= out_decode(S_RST);
            instr_count_r <= '0;
            tmo_r         <= 8'd0;
        end else begin
            state_r <= nxt_state_s;
            {mem_rd_r, load_ir_r, load_pc_r, reset_pc_r, halted_r, fault_r} <= out_decode(nxt_state_s);
            if (start_s && (instr_count_r != CNT_MAX)) begin
                instr_count_r <= instr_count_r + CNT_ONE;
            end else begin
                instr_count_r <= instr_count_r;
            end
            if (state_r == S_EXEC_ACK) begin
                tmo_r <= 8'd0;
            end else if (state_r == S_EXEC_WAIT) begin
                tmo_r <= tmo_r + 8'd1;
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    assign mem_rd      = mem_rd_r;
    assign load_ir     = load_ir_r;
    assign load_pc     = load_pc_r;
    assign reset_pc    = reset_pc_r;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign start       = start_s;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second narrow-counter instance covers saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        waiting;
    logic [2:0]  ir_opcode;
    logic        mem_rd, load_ir, load_pc, reset_pc, start, halted, fault;
    logic [15:0] instr_count;
    logic        mem_rd_b, load_ir_b, load_pc_b, reset_pc_b, start_b, halted_b, fault_b;
    logic [1:0]  instr_count_b;
    logic [6:0]  outs;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam logic [6:0] O_RST   = 7'b0011000;
    localparam logic [6:0] O_IF1   = 7'b1000000;
    localparam logic [6:0] O_IF2   = 7'b1100000;
    localparam logic [6:0] O_UPD   = 7'b0010000;
    localparam logic [6:0] O_START = 7'b0000100;
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_HALT  = 7'b0000010;
    localparam logic [6:0] O_FAULT = 7'b0000001;

    fetch_sequencer #(.CNT_W(16), .TIMEOUT(32), .HALT_OP(3'b111)) dut (
        .clk(clk), .rst(rst), .run(run), .waiting(waiting), .ir_opcode(ir_opcode),
        .mem_rd(mem_rd), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .start(start), .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    fetch_sequencer #(.CNT_W(2), .TIMEOUT(32), .HALT_OP(3'b111)) dut_b (
        .clk(clk), .rst(rst), .run(run), .waiting(waiting), .ir_opcode(ir_opcode),
        .mem_rd(mem_rd_b), .load_ir(load_ir_b), .load_pc(load_pc_b), .reset_pc(reset_pc_b),
        .start(start_b), .halted(halted_b), .fault(fault_b), .instr_count(instr_count_b)
    );

    assign outs = {mem_rd, load_ir, load_pc, reset_pc, start, halted, fault};

    always #5 clk = ~clk;

    // Leaves the bench at a falling edge, in RST, with rst released and run low
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; waiting = 1'b1; ir_opcode = 3'b110;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; waiting = 1'b1; ir_opcode = 3'b110;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (outs !== O_RST) $display("FAIL reset_outs[%0d]: got %b expected %b", i, outs, O_RST);
            else pass_cnt++;
            chk_cnt++;
            if (instr_count !== 16'd0) $display("FAIL reset_count[%0d]: got %0d expected 0", i, instr_count);
            else pass_cnt++;
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [6:0] exp_s [9] = '{O_IF1, O_IF2, O_UPD, O_START, O_IDLE, O_IDLE, O_IDLE, O_IDLE, O_IF1};
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (outs !== exp_s[c-1]) $display("FAIL single_cyc%0d: got %b expected %b", c, outs, exp_s[c-1]);
            else pass_cnt++;
            if (c == 5) waiting = 1'b0;
            if (c == 8) waiting = 1'b1;
        end
        chk_cnt++;
        if (instr_count !== 16'd1) $display("FAIL single_count: got %0d expected 1", instr_count);
        else pass_cnt++;
    endtask

    // Continues from test_single: the second fetch (already in IF1) carries HALT
    task automatic test_halt();
        logic [6:0] exp_s [3] = '{O_IF2, O_UPD, O_IDLE};
        ir_opcode = 3'b111;
        for (int c = 10; c <= 12; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (outs !== exp_s[c-10]) $display("FAIL halt_cyc%0d: got %b expected %b", c, outs, exp_s[c-10]);
            else pass_cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (outs !== O_HALT) $display("FAIL halt_outs[%0d]: got %b expected %b", i, outs, O_HALT);
            else pass_cnt++;
            chk_cnt++;
            if (instr_count !== 16'd1) $display("FAIL halt_count[%0d]: got %0d expected 1", i, instr_count);
            else pass_cnt++;
        end
    endtask

    task automatic test_pause();
        logic [6:0] exp_v;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            exp_v = (c == 1) ? O_IF1 : (c == 2) ? O_IF2 : (c == 3) ? O_UPD :
                    (c == 4) ? O_START : (c == 17) ? O_IF1 : O_IDLE;
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL pause_cyc%0d: got %b expected %b", c, outs, exp_v);
            else pass_cnt++;
            if (c == 2)  run = 1'b0;
            if (c == 4)  waiting = 1'b0;
            if (c == 6)  waiting = 1'b1;
            if (c == 16) run = 1'b1;
        end
        chk_cnt++;
        if (instr_count !== 16'd1) $display("FAIL pause_count: got %0d expected 1", instr_count);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [6:0] exp_v;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            exp_v = (c == 1) ? O_IF1 : (c == 2) ? O_IF2 : (c == 3) ? O_UPD :
                    (c == 4) ? O_START : (c >= 38) ? O_FAULT : O_IDLE;
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL timeout_cyc%0d: got %b expected %b", c, outs, exp_v);
            else pass_cnt++;
            if (c == 4) waiting = 1'b0;
        end
        chk_cnt++;
        if (instr_count !== 16'd1) $display("FAIL timeout_count: got %0d expected 1", instr_count);
        else pass_cnt++;
        // waiting returns during the last allowed cycle: no fault
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            exp_v = (c == 1) ? O_IF1 : (c == 2) ? O_IF2 : (c == 3) ? O_UPD :
                    (c == 4) ? O_START : (c == 38) ? O_IF1 : O_IDLE;
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL late_wait_cyc%0d: got %b expected %b", c, outs, exp_v);
            else pass_cnt++;
            if (c == 4)  waiting = 1'b0;
            if (c == 37) waiting = 1'b1;
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [6:0] exp_s [7] = '{O_IF1, O_IF2, O_UPD, O_START, O_IDLE, O_IDLE, O_IDLE};
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (outs !== exp_s[c-1]) $display("FAIL midrst_cyc%0d: got %b expected %b", c, outs, exp_s[c-1]);
            else pass_cnt++;
            if (c == 4) waiting = 1'b0;
        end
        chk_cnt++;
        if (instr_count !== 16'd1) $display("FAIL midrst_count_before: got %0d expected 1", instr_count);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (outs !== O_RST) $display("FAIL midrst_outs: got %b expected %b", outs, O_RST);
        else pass_cnt++;
        chk_cnt++;
        if (instr_count !== 16'd0) $display("FAIL midrst_count: got %0d expected 0", instr_count);
        else pass_cnt++;
        rst = 1'b0;
        waiting = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (outs !== O_IF1) $display("FAIL midrst_refetch: got %b expected %b", outs, O_IF1);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        int starts = 0;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (start) starts++;
        end
        chk_cnt++;
        if (starts != 5) $display("FAIL sat_starts: got %0d expected 5", starts);
        else pass_cnt++;
        chk_cnt++;
        if (instr_count !== 16'd5) $display("FAIL sat_count_wide: got %0d expected 5", instr_count);
        else pass_cnt++;
        chk_cnt++;
        if (instr_count_b !== 2'd3) $display("FAIL sat_count_narrow: got %0d expected 3", instr_count_b);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_halt();
        test_pause();
        test_timeout();
        test_reset_mid_exec();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Guards against the sequence stalling
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
